// File: rtl/reg_load_arbiter.sv
// ---------------------------------------------------------------------------
// reg_load_arbiter
//
// Shares one WIDTH-bit parallel-load register between two requesters. Each
// granted request:
//   1. drives the latched data onto D with LOAD high for one cycle,
//   2. checks the register's readback Q against that data,
//   3. reloads on a mismatch, up to MAX_RETRY extra times,
//   4. pulses ACK to the requester, with ERR set if the final readback
//      still did not match.
// Grants alternate round-robin between the two requesters.
//
// Timing without retries: REQ is sampled at edge k. GNT and LOAD are high
// after edge k. CHECK follows after edge k+1, and DONE (ACK) after edge k+2.
// The next grant can be taken at edge k+4. Each retry adds two cycles.
//
// Ports:
//   CLK    - system clock, rising edge active
//   CLR_N  - asynchronous active-low reset
//   REQ    - per-requester load request (level, held until ACK)
//   DIN0   - requester 0 write data
//   DIN1   - requester 1 write data
//   Q      - readback from the shared register output
//   D      - data bus to the register's D inputs
//   LOAD   - parallel-load strobe to the register
//   GNT    - one-hot grant (at most one bit set)
//   ACK    - one-cycle completion pulse to the granted requester
//   ERR    - one-cycle pulse alongside ACK when the final readback mismatched
// ---------------------------------------------------------------------------
module reg_load_arbiter #(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic [1:0]       REQ,
  input  logic [WIDTH-1:0] DIN0,
  input  logic [WIDTH-1:0] DIN1,
  input  logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] D,
  output logic             LOAD,
  output logic [1:0]       GNT,
  output logic [1:0]       ACK,
  output logic             ERR
);

  // The retry counter must be able to hold MAX_RETRY.
  // It is kept at least 1 bit wide so that MAX_RETRY = 0 still elaborates.
  localparam int CNT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [1:0]       gnt_q,   gnt_d;
  logic [CNT_W-1:0] retry_q, retry_d;
  logic             ptr_q,   ptr_d;
  logic             err_q,   err_d;
  logic             winner;

  // The pointer's requester wins if it is asking.
  // Otherwise the other requester wins.
  // winner is only used when at least one REQ bit is set.
  always_comb begin
    winner = REQ[ptr_q] ? ptr_q : ~ptr_q;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    gnt_d   = gnt_q;
    retry_d = retry_q;
    ptr_d   = ptr_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (|REQ) begin
          data_d  = winner ? DIN1 : DIN0;
          gnt_d   = winner ? 2'b10 : 2'b01;
          retry_d = '0;
          err_d   = 1'b0;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        state_d = ST_CHECK;
      end

      // Q here already reflects the load strobed in the previous cycle.
      ST_CHECK: begin
        if (Q == data_q) begin
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (retry_q < CNT_W'(MAX_RETRY)) begin
          retry_d = retry_q + CNT_W'(1);
          state_d = ST_LOAD;
        end else begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end

      // Hand priority to the requester that was not just served.
      ST_DONE: begin
        ptr_d   = ~gnt_q[1];
        gnt_d   = 2'b00;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      gnt_q   <= 2'b00;
      retry_q <= '0;
      ptr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      gnt_q   <= gnt_d;
      retry_q <= retry_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  // All outputs decode from registered state only.
  // There is no combinational path from any input to any output.
  assign D    = data_q;
  assign LOAD = (state_q == ST_LOAD);
  assign GNT  = gnt_q;
  assign ACK  = (state_q == ST_DONE) ? gnt_q : 2'b00;
  assign ERR  = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_reg_load_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_load_arbiter
//
// Bench for reg_load_arbiter (WIDTH=4, MAX_RETRY=2).
//
// The shared register is emulated here:
//   - it captures D on every edge where LOAD is high;
//   - 'fault' forces its readback Q to zero.
//
// The reference model describes each transaction by its cycle offset t
// from the grant edge. Given the number of load attempts a:
//   - LOAD is high at even t < 2a;
//   - ACK (and ERR when the readback never matched) is high at t = 2a;
//   - the arbiter is idle again from t = 2a+1.
//
// Directed sections pin the model with hand-computed literals. A random
// phase then exercises arbitration, drops, re-requests and faults.
// ---------------------------------------------------------------------------
module tb_reg_load_arbiter;

  localparam int WIDTH     = 4;
  localparam int MAX_RETRY = 2;

  logic             CLK;
  logic             CLR_N;
  logic [1:0]       REQ;
  logic [WIDTH-1:0] DIN0;
  logic [WIDTH-1:0] DIN1;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] D;
  logic             LOAD;
  logic [1:0]       GNT;
  logic [1:0]       ACK;
  logic             ERR;

  int checks   = 0;
  int failures = 0;

  logic             fault  = 1'b0;
  logic [WIDTH-1:0] reg_q  = '0;
  bit               cmp_en = 1'b0;

  // Reference-model state.
  bit               m_busy = 1'b0;
  int               m_t    = 0;
  int               m_att  = 1;
  bit               m_win  = 1'b0;
  bit               m_ptr  = 1'b0;
  bit               m_err  = 1'b0;
  logic [WIDTH-1:0] m_data = '0;

  reg_load_arbiter #(
    .WIDTH    (WIDTH),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .CLK  (CLK),
    .CLR_N(CLR_N),
    .REQ  (REQ),
    .DIN0 (DIN0),
    .DIN1 (DIN1),
    .Q    (Q),
    .D    (D),
    .LOAD (LOAD),
    .GNT  (GNT),
    .ACK  (ACK),
    .ERR  (ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Emulated parallel-load register with an optional stuck-at-zero readback.
  always @(posedge CLK) begin
    if (LOAD) reg_q <= D;
  end
  assign Q = fault ? '0 : reg_q;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] req,
                               input logic [WIDTH-1:0] d0,
                               input logic [WIDTH-1:0] d1);
    @(negedge CLK);
    REQ  = req;
    DIN0 = d0;
    DIN1 = d1;
  endtask

  task automatic stepSample();
    @(posedge CLK);
    #1;
  endtask

  // Steps until ACK is seen, within a bounded number of cycles.
  // Returns the ACK value, the number of cycles taken, and how many LOAD
  // pulses occurred along the way.
  task automatic waitAck(output logic [1:0] ack_seen, output int cycles,
                         output int loads);
    ack_seen = 2'b00;
    cycles   = 0;
    loads    = 0;
    for (int i = 0; i < 50; i++) begin
      stepSample();
      cycles++;
      if (LOAD) loads++;
      if (ACK != 2'b00) begin
        ack_seen = ACK;
        break;
      end
    end
    if (ack_seen == 2'b00) checkOutput("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic doReset();
    @(negedge CLK);
    CLR_N = 1'b0;
    REQ   = 2'b00;
    #2;
    @(negedge CLK);
    CLR_N = 1'b1;
  endtask

  // Reference model, advanced on every edge and on asynchronous reset.
  initial begin
    forever begin
      @(posedge CLK or negedge CLR_N);
      if (!CLR_N) begin
        m_busy = 1'b0;
        m_t    = 0;
        m_att  = 1;
        m_ptr  = 1'b0;
        m_win  = 1'b0;
        m_err  = 1'b0;
        m_data = '0;
      end else if (m_busy) begin
        m_t++;
        if (m_t > 2 * m_att) m_busy = 1'b0;
      end else if (REQ != 2'b00) begin
        m_win  = REQ[m_ptr] ? m_ptr : ~m_ptr;
        m_data = m_win ? DIN1 : DIN0;
        m_err  = fault && (m_data != '0);
        m_att  = m_err ? MAX_RETRY + 1 : 1;
        m_ptr  = ~m_win;
        m_busy = 1'b1;
        m_t    = 0;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  initial begin
    logic [1:0] exp_gnt;
    logic [1:0] exp_ack;
    logic       exp_load;
    logic       exp_err;
    forever begin
      @(posedge CLK);
      #1;
      if (cmp_en && CLR_N) begin
        exp_gnt  = m_busy ? (m_win ? 2'b10 : 2'b01) : 2'b00;
        exp_load = m_busy && (m_t < 2 * m_att) && (m_t % 2 == 0);
        exp_ack  = (m_busy && m_t == 2 * m_att) ? exp_gnt : 2'b00;
        exp_err  = m_busy && (m_t == 2 * m_att) && m_err;
        checkOutput("model_D",    32'(D),    32'(m_data));
        checkOutput("model_GNT",  32'(GNT),  32'(exp_gnt));
        checkOutput("model_LOAD", 32'(LOAD), 32'(exp_load));
        checkOutput("model_ACK",  32'(ACK),  32'(exp_ack));
        checkOutput("model_ERR",  32'(ERR),  32'(exp_err));
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] ack;
    logic [1:0] r;
    int         cyc;
    int         lds;

    CLR_N = 1'b1;
    REQ   = 2'b00;
    DIN0  = '0;
    DIN1  = '0;

    // Asynchronous reset asserted mid-cycle must clear outputs immediately.
    #7;
    CLR_N = 1'b0;
    #1;
    checkOutput("rst_D",    32'(D),    32'h0);
    checkOutput("rst_LOAD", 32'(LOAD), 32'h0);
    checkOutput("rst_GNT",  32'(GNT),  32'h0);
    checkOutput("rst_ACK",  32'(ACK),  32'h0);
    checkOutput("rst_ERR",  32'(ERR),  32'h0);
    @(negedge CLK);
    CLR_N  = 1'b1;
    cmp_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      stepSample();
      checkOutput("idle_GNT",  32'(GNT),  32'h0);
      checkOutput("idle_LOAD", 32'(LOAD), 32'h0);
    end

    // Single request from requester 0.
    applyStimulus(2'b01, 4'b0110, 4'h0);
    stepSample();
    checkOutput("single_GNT",  32'(GNT),  32'h1);
    checkOutput("single_LOAD", 32'(LOAD), 32'h1);
    checkOutput("single_D",    32'(D),    32'h6);
    waitAck(ack, cyc, lds);
    checkOutput("single_ACK", 32'(ack), 32'h1);
    checkOutput("single_lat", 32'(cyc), 32'd2);
    checkOutput("single_ERR", 32'(ERR), 32'h0);
    applyStimulus(2'b00, 4'h0, 4'h0);

    // Contention from reset: requester 0 first, then requester 1.
    doReset();
    applyStimulus(2'b11, 4'h3, 4'hC);
    stepSample();
    checkOutput("cont0_GNT", 32'(GNT), 32'h1);
    checkOutput("cont0_D",   32'(D),   32'h3);
    waitAck(ack, cyc, lds);
    checkOutput("cont0_ACK", 32'(ack), 32'h1);
    stepSample();
    checkOutput("cont_gap_GNT", 32'(GNT), 32'h0);
    stepSample();
    checkOutput("cont1_GNT", 32'(GNT), 32'h2);
    checkOutput("cont1_D",   32'(D),   32'hC);
    waitAck(ack, cyc, lds);
    checkOutput("cont1_ACK", 32'(ack), 32'h2);

    // Round-robin fairness with both requests held continuously.
    for (int i = 0; i < 8; i++) begin
      waitAck(ack, cyc, lds);
      checkOutput("rr_ACK", 32'(ack), (i % 2 == 0) ? 32'h1 : 32'h2);
    end
    applyStimulus(2'b00, 4'h0, 4'h0);
    stepSample();
    stepSample();

    // Readback stuck at zero: three loads, then ACK with ERR.
    fault = 1'b1;
    applyStimulus(2'b10, 4'h0, 4'h9);
    stepSample();
    checkOutput("fault_GNT", 32'(GNT), 32'h2);
    waitAck(ack, cyc, lds);
    checkOutput("fault_ACK",   32'(ack),     32'h2);
    checkOutput("fault_ERR",   32'(ERR),     32'h1);
    checkOutput("fault_lat",   32'(cyc),     32'd6);
    checkOutput("fault_loads", 32'(lds + 1), 32'd3);
    applyStimulus(2'b00, 4'h0, 4'h9);
    stepSample();
    fault = 1'b0;
    applyStimulus(2'b10, 4'h0, 4'h9);
    stepSample();
    waitAck(ack, cyc, lds);
    checkOutput("nofault_ACK",   32'(ack),     32'h2);
    checkOutput("nofault_ERR",   32'(ERR),     32'h0);
    checkOutput("nofault_loads", 32'(lds + 1), 32'd1);
    applyStimulus(2'b00, 4'h0, 4'h0);
    stepSample();

    // REQ dropped during LOAD: the transaction still completes.
    applyStimulus(2'b01, 4'h5, 4'h0);
    stepSample();
    applyStimulus(2'b00, 4'hA, 4'h0);
    waitAck(ack, cyc, lds);
    checkOutput("drop_ACK", 32'(ack), 32'h1);
    checkOutput("drop_D",   32'(D),   32'h5);
    stepSample();

    // Reset during CHECK aborts silently; requester 1 is then served.
    applyStimulus(2'b01, 4'h7, 4'h0);
    stepSample();
    stepSample();
    CLR_N = 1'b0;
    REQ   = 2'b00;
    #1;
    checkOutput("abort_ACK", 32'(ACK), 32'h0);
    checkOutput("abort_GNT", 32'(GNT), 32'h0);
    stepSample();
    checkOutput("abort_hold_ACK", 32'(ACK), 32'h0);
    @(negedge CLK);
    CLR_N = 1'b1;
    applyStimulus(2'b10, 4'h0, 4'hA);
    stepSample();
    checkOutput("post_abort_GNT", 32'(GNT), 32'h2);
    waitAck(ack, cyc, lds);
    checkOutput("post_abort_ACK", 32'(ack), 32'h2);
    applyStimulus(2'b00, 4'h0, 4'h0);

    // Random traffic: requests, re-requests, drops, data churn and faults.
    for (int c = 0; c < 600; c++) begin
      @(negedge CLK);
      if (!m_busy) fault = ($urandom_range(0, 5) == 0);
      r = REQ;
      for (int i = 0; i < 2; i++) begin
        if (ACK[i])        r[i] = ($urandom_range(0, 3) == 0);
        else if (!r[i])    r[i] = ($urandom_range(0, 2) == 0);
        else if ($urandom_range(0, 19) == 0) r[i] = 1'b0;
      end
      REQ  = r;
      DIN0 = 4'($urandom);
      DIN1 = 4'($urandom);
    end

    @(negedge CLK);
    REQ = 2'b00;
    for (int i = 0; i < 12; i++) stepSample();
    fault = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
